// File: rtl/dot_pkg.sv
// Shared types and defaults for the dot-product sequencer.
package dot_pkg;

   localparam int unsigned DOT_ROWS_DEF = 4;
   localparam int unsigned DOT_COLS_DEF = 4;
   localparam int unsigned FP32_W       = 32;

   typedef logic [FP32_W-1:0] fp32_t;

   typedef enum logic [1:0] {
      LOAD,
      COMPUTE,
      WAIT,
      SEND
   } dot_state_e;

endpackage

// File: rtl/dot_term_fetch.sv
// Fetch/issue stage: reads W[r][col] from the ROM and presents (x[r], W[r][col]) to the MAC.
module dot_term_fetch
   import dot_pkg::*;
#(
   parameter int unsigned ROWS = DOT_ROWS_DEF,
   parameter int unsigned COLS = DOT_COLS_DEF,
   parameter int unsigned AW   = $clog2(ROWS * COLS),
   parameter int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          active,
   input  logic [CW-1:0] col,
   input  fp32_t         x [ROWS],
   input  fp32_t         rom_dout,
   input  logic          mac_in_ready,
   output logic          rom_en,
   output logic [AW-1:0] rom_addr,
   output fp32_t         mac_a,
   output fp32_t         mac_b,
   output logic          mac_clr,
   output logic          mac_last,
   output logic          mac_in_valid,
   output logic          col_done_c
);

   localparam int unsigned   RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   logic [RW-1:0] f_row;
   logic          fetched;
   logic          drain;

   // ROM is read only when the issue slot is free or empties this cycle, so a stall holds rom_dout
   assign drain      = mac_in_valid && mac_in_ready;
   assign rom_en     = active && !fetched && (!mac_in_valid || mac_in_ready);
   assign rom_addr   = AW'(AW'(f_row) * AW'(COLS) + AW'(col));
   assign mac_b      = rom_dout;
   assign col_done_c = drain && mac_last;

   // fetch row counter, restarted whenever the column is not being computed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_row   <= '0;
         fetched <= 1'b0;
      end else if (!active) begin
         f_row   <= '0;
         fetched <= 1'b0;
      end else if (rom_en) begin
         f_row   <= (f_row == ROW_LAST) ? '0 : f_row + 1'b1;
         fetched <= (f_row == ROW_LAST);
      end
   end

   // issue stage register: loads with each fetch, empties on a MAC handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mac_in_valid <= 1'b0;
         mac_a        <= '0;
         mac_clr      <= 1'b0;
         mac_last     <= 1'b0;
      end else if (rom_en) begin
         mac_in_valid <= 1'b1;
         mac_a        <= x[f_row];
         mac_clr      <= (f_row == '0);
         mac_last     <= (f_row == ROW_LAST);
      end else if (drain || !active) begin
         mac_in_valid <= 1'b0;
         mac_clr      <= 1'b0;
         mac_last     <= 1'b0;
      end
   end

endmodule

// File: rtl/dot_seq_ctrl.sv
// Sequencer for a shared FP32 MAC computing y = x^T * W, one output column at a time.
module dot_seq_ctrl
   import dot_pkg::*;
#(
   parameter int unsigned ROWS = DOT_ROWS_DEF,
   parameter int unsigned COLS = DOT_COLS_DEF,
   parameter int unsigned AW   = $clog2(ROWS * COLS)
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  fp32_t         INPUT_AXIS_TDATA,
   input  logic          INPUT_AXIS_TLAST,
   input  logic          INPUT_AXIS_TVALID,
   output logic          INPUT_AXIS_TREADY,
   output fp32_t         OUTPUT_AXIS_TDATA,
   output logic          OUTPUT_AXIS_TLAST,
   output logic          OUTPUT_AXIS_TVALID,
   input  logic          OUTPUT_AXIS_TREADY,
   output logic          rom_en,
   output logic [AW-1:0] rom_addr,
   input  fp32_t         rom_dout,
   output fp32_t         mac_a,
   output fp32_t         mac_b,
   output logic          mac_clr,
   output logic          mac_last,
   output logic          mac_in_valid,
   input  logic          mac_in_ready,
   input  fp32_t         mac_out_data,
   input  logic          mac_out_valid,
   output logic          err_tlast
);

   localparam int unsigned   RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned   CW       = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

   dot_state_e    state;
   dot_state_e    state_nxt;
   logic [RW-1:0] r;
   logic [CW-1:0] c;
   fp32_t         x [ROWS];
   logic          in_hs;
   logic          out_hs;
   logic          col_done;
   logic          compute_active;
   logic          load_exit;
   logic          early_last;
   logic          missing_last;

   assign in_hs          = INPUT_AXIS_TVALID && INPUT_AXIS_TREADY;
   assign out_hs         = OUTPUT_AXIS_TVALID && OUTPUT_AXIS_TREADY;
   assign compute_active = (state == COMPUTE);

   // state register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= LOAD;
      else          state <= state_nxt;
   end

   // next state and input-length decode
   always_comb begin
      state_nxt    = state;
      load_exit    = 1'b0;
      early_last   = 1'b0;
      missing_last = 1'b0;
      case (state)
         LOAD: begin
            if (in_hs) begin
               if (r == ROW_LAST) begin
                  load_exit    = 1'b1;
                  missing_last = !INPUT_AXIS_TLAST;
               end else if (INPUT_AXIS_TLAST) begin
                  load_exit  = 1'b1;
                  early_last = 1'b1;
               end
               if (load_exit) state_nxt = COMPUTE;
            end
         end
         COMPUTE: if (col_done) state_nxt = WAIT;
         WAIT:    if (mac_out_valid) state_nxt = SEND;
         SEND:    if (out_hs) state_nxt = (c == COL_LAST) ? LOAD : COMPUTE;
         default: state_nxt = LOAD;
      endcase
   end

   // x buffer: store each beat; a short vector has its tail zeroed
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int unsigned i = 0; i < ROWS; i++) x[i] <= '0;
      end else if (in_hs) begin
         for (int unsigned i = 0; i < ROWS; i++) begin
            if (RW'(i) == r)                      x[i] <= INPUT_AXIS_TDATA;
            else if (early_last && (RW'(i) > r))  x[i] <= '0;
         end
      end
   end

   // row counter for loading, column counter advanced by each result handshake
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r <= '0;
         c <= '0;
      end else begin
         if (in_hs)  r <= load_exit ? '0 : r + 1'b1;
         if (out_hs) c <= (c == COL_LAST) ? '0 : c + 1'b1;
      end
   end

   // sticky input-length error
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) err_tlast <= 1'b0;
      else if (early_last || missing_last) err_tlast <= 1'b1;
   end

   // stream handshake flags and the result register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         INPUT_AXIS_TREADY  <= 1'b1;
         OUTPUT_AXIS_TVALID <= 1'b0;
         OUTPUT_AXIS_TLAST  <= 1'b0;
         OUTPUT_AXIS_TDATA  <= '0;
      end else begin
         INPUT_AXIS_TREADY  <= (state_nxt == LOAD);
         OUTPUT_AXIS_TVALID <= (state_nxt == SEND);
         if ((state == WAIT) && mac_out_valid) begin
            OUTPUT_AXIS_TDATA <= mac_out_data;
            OUTPUT_AXIS_TLAST <= (c == COL_LAST);
         end else if (out_hs) begin
            OUTPUT_AXIS_TLAST <= 1'b0;
         end
      end
   end

   // fetch/issue pipeline toward the ROM and MAC
   dot_term_fetch #(
      .ROWS (ROWS),
      .COLS (COLS),
      .AW   (AW),
      .CW   (CW)
   ) u_fetch (
      .clk          (aclk),
      .rst_n        (aresetn),
      .active       (compute_active),
      .col          (c),
      .x            (x),
      .rom_dout     (rom_dout),
      .mac_in_ready (mac_in_ready),
      .rom_en       (rom_en),
      .rom_addr     (rom_addr),
      .mac_a        (mac_a),
      .mac_b        (mac_b),
      .mac_clr      (mac_clr),
      .mac_last     (mac_last),
      .mac_in_valid (mac_in_valid),
      .col_done_c   (col_done)
   );

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Directed bench for dot_seq_ctrl with a behavioural weight ROM and ideal 1-cycle MAC.
module tb_dot_seq_ctrl;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] INPUT_AXIS_TDATA = '0;
   logic        INPUT_AXIS_TLAST = 1'b0;
   logic        INPUT_AXIS_TVALID = 1'b0;
   logic        INPUT_AXIS_TREADY;
   logic [31:0] OUTPUT_AXIS_TDATA;
   logic        OUTPUT_AXIS_TLAST;
   logic        OUTPUT_AXIS_TVALID;
   logic        OUTPUT_AXIS_TREADY = 1'b0;
   logic        rom_en;
   logic [3:0]  rom_addr;
   logic [31:0] rom_dout = '0;
   logic [31:0] mac_a, mac_b;
   logic        mac_clr, mac_last, mac_in_valid, mac_in_ready;
   logic [31:0] mac_out_data;
   logic        mac_out_valid;
   logic        err_tlast;

   logic        tog = 1'b0;
   logic        tog_mode = 1'b0;
   logic        stray = 1'b0;
   logic        mac_ov;
   real         acc;
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          hs_n = 0;
   logic [3:0]  addr_q [$];
   logic [31:0] xv [4] = '{32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3ECCCCCD};
   real         ey [4];

   dot_seq_ctrl dut (
      .aclk               (aclk),
      .aresetn            (aresetn),
      .INPUT_AXIS_TDATA   (INPUT_AXIS_TDATA),
      .INPUT_AXIS_TLAST   (INPUT_AXIS_TLAST),
      .INPUT_AXIS_TVALID  (INPUT_AXIS_TVALID),
      .INPUT_AXIS_TREADY  (INPUT_AXIS_TREADY),
      .OUTPUT_AXIS_TDATA  (OUTPUT_AXIS_TDATA),
      .OUTPUT_AXIS_TLAST  (OUTPUT_AXIS_TLAST),
      .OUTPUT_AXIS_TVALID (OUTPUT_AXIS_TVALID),
      .OUTPUT_AXIS_TREADY (OUTPUT_AXIS_TREADY),
      .rom_en             (rom_en),
      .rom_addr           (rom_addr),
      .rom_dout           (rom_dout),
      .mac_a              (mac_a),
      .mac_b              (mac_b),
      .mac_clr            (mac_clr),
      .mac_last           (mac_last),
      .mac_in_valid       (mac_in_valid),
      .mac_in_ready       (mac_in_ready),
      .mac_out_data       (mac_out_data),
      .mac_out_valid      (mac_out_valid),
      .err_tlast          (err_tlast)
   );

   always #5 aclk = ~aclk;

   assign mac_in_ready  = tog_mode ? tog : 1'b1;
   assign mac_out_valid = mac_ov | stray;

   // FP32 <-> real for normal numbers and zero
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == '0) return 0.0;
      d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real v);
      logic [63:0] d;
      int          e;
      logic [23:0] m;
      if (v == 0.0) return '0;
      d = $realtobits(v);
      e = int'(d[62:52]) - 1023 + 127;
      m = {1'b0, d[51:29]};
      if (d[28] && ((|d[27:0]) || m[0])) m = m + 24'd1;
      if (m[23]) begin
         e = e + 1;
         m = '0;
      end
      return {d[63], 8'(e), m[22:0]};
   endfunction

   function automatic longint um(input real v);
      return longint'($rtoi(v * 1.0e6 + 0.5));
   endfunction

   function automatic real term(input logic [31:0] a, input logic [31:0] b);
      return f2r(a) * f2r(b);
   endfunction

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // weight ROM: W[r][c] = 9.0 + c, registered read
   always @(posedge aclk) if (rom_en) rom_dout <= r2f(9.0 + real'(int'(rom_addr[1:0])));

   // ideal MAC, result one cycle after the last term
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         acc          <= 0.0;
         mac_ov       <= 1'b0;
         mac_out_data <= '0;
      end else begin
         mac_ov <= 1'b0;
         if (mac_in_valid && mac_in_ready) begin
            acc <= (mac_clr ? 0.0 : acc) + term(mac_a, mac_b);
            if (mac_last) begin
               mac_ov       <= 1'b1;
               mac_out_data <= r2f((mac_clr ? 0.0 : acc) + term(mac_a, mac_b));
            end
         end
      end
   end

   // cycle counter and ROM/MAC traffic log
   always @(posedge aclk) begin
      cyc <= cyc + 1;
      if (aresetn && rom_en) addr_q.push_back(rom_addr);
      if (aresetn && mac_in_valid && mac_in_ready) hs_n <= hs_n + 1;
   end

   always @(negedge aclk) tog = ~tog;

   task automatic send(input int n, input int last_at);
      int k;
      for (int i = 0; i < n; i++) begin
         @(negedge aclk);
         INPUT_AXIS_TVALID = 1'b1;
         INPUT_AXIS_TDATA  = xv[i];
         INPUT_AXIS_TLAST  = (i == last_at);
         k = 0;
         while (!INPUT_AXIS_TREADY && k < 200) begin
            @(negedge aclk);
            k++;
         end
         if (!INPUT_AXIS_TREADY) chk("in_ready_timeout", longint'(INPUT_AXIS_TREADY), 1);
         @(posedge aclk);
      end
      @(negedge aclk);
      INPUT_AXIS_TVALID = 1'b0;
      INPUT_AXIS_TLAST  = 1'b0;
   endtask

   task automatic recv(input int nb, input int stall);
      int          k;
      logic [31:0] d;
      logic        l;
      logic        hold_ok;
      for (int c = 0; c < nb; c++) begin
         OUTPUT_AXIS_TREADY = (stall == 0);
         k = 0;
         while (!OUTPUT_AXIS_TVALID && k < 300) begin
            @(negedge aclk);
            k++;
         end
         chk($sformatf("out_valid%0d", c), longint'(OUTPUT_AXIS_TVALID), 1);
         if (!OUTPUT_AXIS_TVALID) return;
         d = OUTPUT_AXIS_TDATA;
         l = OUTPUT_AXIS_TLAST;
         hold_ok = 1'b1;
         for (int s = 0; s < stall; s++) begin
            @(negedge aclk);
            hold_ok &= (OUTPUT_AXIS_TDATA == d) && (OUTPUT_AXIS_TLAST == l) &&
                       OUTPUT_AXIS_TVALID && !INPUT_AXIS_TREADY;
         end
         if (stall > 0) chk($sformatf("hold%0d", c), longint'(hold_ok), 1);
         OUTPUT_AXIS_TREADY = 1'b1;
         @(posedge aclk);
         @(negedge aclk);
         chk($sformatf("y%0d_micro", c), um(f2r(d)), um(ey[c]));
         chk($sformatf("tlast%0d", c), longint'(l), longint'(c == 3));
      end
      OUTPUT_AXIS_TREADY = 1'b0;
      if (nb == 4) chk("in_ready_after_last", longint'(INPUT_AXIS_TREADY), 1);
   endtask

   task automatic run(input int n, input int last_at, input int stall);
      fork
         send(n, last_at);
         recv(4, stall);
      join
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog at cycle %0d", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      int base_a, base_h, t0, k;
      logic quiet;

      // reset values
      repeat (3) @(negedge aclk);
      chk("rst_in_ready", longint'(INPUT_AXIS_TREADY), 1);
      chk("rst_out_valid", longint'(OUTPUT_AXIS_TVALID), 0);
      chk("rst_rom_en", longint'(rom_en), 0);
      chk("rst_mac_valid", longint'(mac_in_valid), 0);
      chk("rst_err", longint'(err_tlast), 0);
      aresetn = 1'b1;

      // 1: nominal
      ey = '{9.0, 10.0, 11.0, 12.0};
      run(4, 3, 0);
      chk("s1_err", longint'(err_tlast), 0);

      // 2: MAC backpressure, rom_addr order and term count
      base_a = addr_q.size();
      base_h = hs_n;
      tog_mode = 1'b1;
      run(4, 3, 0);
      tog_mode = 1'b0;
      chk("s2_terms", longint'(hs_n - base_h), 16);
      chk("s2_fetches", longint'(addr_q.size() - base_a), 16);
      for (int i = 0; i < 16; i++)
         if (base_a + i < addr_q.size())
            chk($sformatf("s2_addr%0d", i), longint'(addr_q[base_a + i]), longint'((i % 4) * 4 + i / 4));

      // 3: output backpressure, 5 stalled cycles per beat
      run(4, 3, 5);
      chk("s3_err", longint'(err_tlast), 0);

      // 4: early TLAST after x[1]
      ey = '{2.7, 3.0, 3.3, 3.6};
      run(2, 1, 0);
      chk("s4_err", longint'(err_tlast), 1);

      // 5: back-to-back full vectors, cycle budget
      ey = '{9.0, 10.0, 11.0, 12.0};
      for (int v = 0; v < 2; v++) begin
         t0 = cyc;
         run(4, 3, 0);
         chk($sformatf("s5_cycles_le40_run%0d", v), longint'((cyc - t0) <= 40), 1);
      end
      chk("s5_err_sticky", longint'(err_tlast), 1);

      // 6: reset while waiting on the third column's sum
      fork
         send(4, 3);
         recv(2, 0);
      join
      k = 0;
      while (!(mac_in_valid && mac_last) && k < 50) begin
         @(negedge aclk);
         k++;
      end
      chk("s6_last_term_seen", longint'(mac_in_valid && mac_last), 1);
      @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b0;
      #1;
      chk("s6_out_valid", longint'(OUTPUT_AXIS_TVALID), 0);
      chk("s6_out_data", longint'(OUTPUT_AXIS_TDATA), 0);
      chk("s6_rom_en", longint'(rom_en), 0);
      chk("s6_mac_valid", longint'(mac_in_valid), 0);
      chk("s6_err_cleared", longint'(err_tlast), 0);
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      chk("s6_in_ready", longint'(INPUT_AXIS_TREADY), 1);
      stray = 1'b1;
      @(negedge aclk);
      stray = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge aclk);
         quiet &= !OUTPUT_AXIS_TVALID && INPUT_AXIS_TREADY;
      end
      chk("s6_stray_ignored", longint'(quiet), 1);
      run(4, 3, 0);
      chk("s6_fresh_err", longint'(err_tlast), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
